// File: rtl/pl_pkg.sv
// Shared types and constants for the execute stage and its RNS reducer.
package pl_pkg;

    localparam int unsigned LANE_W = 8;
    localparam int unsigned PROD_W = 2 * LANE_W;
    localparam int unsigned CNT_W  = 3;

    typedef enum logic [2:0] {
        ALU_ADD    = 3'd0,
        ALU_SUB    = 3'd1,
        ALU_AND    = 3'd2,
        ALU_OR     = 3'd3,
        ALU_XOR    = 3'd4,
        ALU_MUL    = 3'd5,
        ALU_CMP    = 3'd6,
        ALU_PASS_B = 3'd7
    } alu_op_e;

    // Bit positions inside ID_reg / EX_reg.
    typedef enum int unsigned {
        EX_STORE_TO_MEM         = 0,
        EX_REG_WR_EN            = 1,
        EX_SAVE_COUT            = 2,
        EX_INVALIDATE_EXECUTE   = 3,
        EX_LOAD_TRUE            = 4,
        EX_INVALIDATE_FETCH     = 5,
        EX_INVALIDATE_DECODE    = 6,
        EX_DEST_RNS             = 7
    } ex_bit_e;

    // Bit positions inside branch_conds_EX.
    typedef enum int unsigned {
        BC_EQ    = 0,
        BC_GT    = 1,
        BC_LT    = 2,
        BC_CARRY = 3,
        BC_CMP   = 4
    } bc_bit_e;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_REDUCE = 1'b1
    } ex_state_e;

    // Modular add for operands already below m.
    function automatic logic [LANE_W-1:0] rns_add(input logic [LANE_W-1:0] a,
                                                  input logic [LANE_W-1:0] b,
                                                  input logic [LANE_W-1:0] m);
        logic [LANE_W:0] s;
        s = (LANE_W+1)'(a) + (LANE_W+1)'(b);
        if (s >= (LANE_W+1)'(m)) s = s - (LANE_W+1)'(m);
        return s[LANE_W-1:0];
    endfunction

    // Modular subtract for operands already below m.
    function automatic logic [LANE_W-1:0] rns_sub(input logic [LANE_W-1:0] a,
                                                  input logic [LANE_W-1:0] b,
                                                  input logic [LANE_W-1:0] m);
        logic [LANE_W:0] s;
        if (a >= b) s = (LANE_W+1)'(a) - (LANE_W+1)'(b);
        else        s = (LANE_W+1)'(a) + (LANE_W+1)'(m) - (LANE_W+1)'(b);
        return s[LANE_W-1:0];
    endfunction

endpackage

// File: rtl/pl_ex_stage_if.sv
// ID -> EX -> MEM/WB bundle; master is the ID side, slave is the EX stage.
interface pl_ex_stage_if
    import pl_pkg::*;
#(
    parameter int unsigned NUM_DOMAINS = 1
);
    logic                            in_valid;
    alu_op_e                         alu_op;
    logic [NUM_DOMAINS*LANE_W-1:0]   op_a;
    logic [NUM_DOMAINS*LANE_W-1:0]   op_b;
    logic [0:7]                      ID_reg;
    logic                            flush;
    logic                            stall_out;
    logic [NUM_DOMAINS*LANE_W-1:0]   operation_result;
    logic [0:7]                      EX_reg;
    logic [0:4]                      branch_conds_EX;

    modport master (
        output in_valid, alu_op, op_a, op_b, ID_reg, flush,
        input  stall_out, operation_result, EX_reg, branch_conds_EX
    );

    modport slave (
        input  in_valid, alu_op, op_a, op_b, ID_reg, flush,
        output stall_out, operation_result, EX_reg, branch_conds_EX
    );
endinterface

// File: rtl/rns_mod_reducer.sv
// One RNS lane: latches a*b, then reduces mod MODULUS by shift-subtract over 8 steps.
module rns_mod_reducer
    import pl_pkg::*;
#(
    parameter logic [LANE_W-1:0] MODULUS = 8'd255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              flush,
    input  logic [LANE_W-1:0] a,
    input  logic [LANE_W-1:0] b,
    output logic [LANE_W-1:0] result,
    output logic              done
);
    logic [PROD_W-1:0] prod_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              busy_q;
    logic [PROD_W-1:0] shifted_m;

    assign shifted_m = PROD_W'(MODULUS) << cnt_q;
    assign result    = prod_q[LANE_W-1:0];

    // Product latch and one conditional subtract of m<<cnt per cycle.
    always_ff @(posedge clk) begin
        if (!reset) begin
            prod_q <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
            done   <= 1'b0;
        end else if (flush) begin
            cnt_q  <= '0;
            busy_q <= 1'b0;
            done   <= 1'b0;
        end else if (start) begin
            prod_q <= PROD_W'(a) * PROD_W'(b);
            cnt_q  <= CNT_W'(7);
            busy_q <= 1'b1;
            done   <= 1'b0;
        end else if (busy_q) begin
            if (prod_q >= shifted_m) prod_q <= prod_q - shifted_m;
            cnt_q <= cnt_q - CNT_W'(1);
            if (cnt_q == '0) begin
                busy_q <= 1'b0;
                done   <= 1'b1;
            end
        end else begin
            done <= 1'b0;
        end
    end
endmodule

// File: rtl/pl_ex_stage.sv
// Execute stage: binary ALU on lane 0 or per-lane RNS ALU, iterative RNS multiply.
module pl_ex_stage
    import pl_pkg::*;
#(
    parameter int unsigned                 NUM_DOMAINS  = 1,
    parameter int unsigned                 PROG_CTR_WID = 10,
    parameter logic [NUM_DOMAINS*8-1:0]    MODULI       = {NUM_DOMAINS{8'd255}}
) (
    input  logic          clk,
    input  logic          reset,
    pl_ex_stage_if.slave  ex
);
    localparam int unsigned DW = NUM_DOMAINS * LANE_W;

    if (PROG_CTR_WID == 0) begin : g_bad_pc_wid
        $error("pl_ex_stage: PROG_CTR_WID must be nonzero");
    end

    ex_state_e      state_q, state_d;
    logic [0:7]     pend_q, pend_d;
    logic [DW-1:0]  res_d;
    logic [0:7]     exr_d;
    logic [0:4]     bc_d;
    logic [DW-1:0]  alu_res;
    logic [0:4]     alu_bc;
    logic [DW-1:0]  red_res;
    logic [NUM_DOMAINS-1:0] red_done;
    logic           mul_start_c;
    logic           is_rns;
    logic [LANE_W-1:0] a0, b0;
    logic [LANE_W:0]   sum9;
    logic [PROD_W-1:0] prod0;

    assign is_rns       = ex.ID_reg[EX_DEST_RNS];
    assign a0           = ex.op_a[LANE_W-1:0];
    assign b0           = ex.op_b[LANE_W-1:0];
    assign ex.stall_out = (state_q == ST_REDUCE);

    for (genvar i = 0; i < NUM_DOMAINS; i++) begin : g_lane
        rns_mod_reducer #(
            .MODULUS (MODULI[i*LANE_W +: LANE_W])
        ) u_reducer (
            .clk    (clk),
            .reset  (reset),
            .start  (mul_start_c),
            .flush  (ex.flush),
            .a      (ex.op_a[i*LANE_W +: LANE_W]),
            .b      (ex.op_b[i*LANE_W +: LANE_W]),
            .result (red_res[i*LANE_W +: LANE_W]),
            .done   (red_done[i])
        );
    end

    // Single-cycle ALU result and branch conditions for the presented instruction.
    always_comb begin
        alu_res = '0;
        alu_bc  = '0;
        sum9    = '0;
        prod0   = '0;
        if (!is_rns) begin
            unique case (ex.alu_op)
                ALU_ADD: begin
                    sum9 = (LANE_W+1)'(a0) + (LANE_W+1)'(b0);
                    alu_res[LANE_W-1:0] = sum9[LANE_W-1:0];
                    alu_bc[BC_CARRY]    = sum9[LANE_W];
                end
                ALU_SUB: begin
                    alu_res[LANE_W-1:0] = a0 - b0;
                    alu_bc[BC_CARRY]    = (a0 < b0);
                end
                ALU_AND:    alu_res[LANE_W-1:0] = a0 & b0;
                ALU_OR:     alu_res[LANE_W-1:0] = a0 | b0;
                ALU_XOR:    alu_res[LANE_W-1:0] = a0 ^ b0;
                ALU_PASS_B: alu_res[LANE_W-1:0] = b0;
                ALU_MUL: begin
                    prod0 = PROD_W'(a0) * PROD_W'(b0);
                    alu_res[LANE_W-1:0] = prod0[LANE_W-1:0];
                    alu_bc[BC_CARRY]    = |prod0[PROD_W-1:LANE_W];
                end
                ALU_CMP: begin
                    alu_bc[BC_EQ]  = (a0 == b0);
                    alu_bc[BC_GT]  = (a0 > b0);
                    alu_bc[BC_LT]  = (a0 < b0);
                    alu_bc[BC_CMP] = 1'b1;
                end
                default: ;
            endcase
        end else begin
            for (int i = 0; i < NUM_DOMAINS; i++) begin
                unique case (ex.alu_op)
                    ALU_ADD: alu_res[i*LANE_W +: LANE_W] =
                        rns_add(ex.op_a[i*LANE_W +: LANE_W], ex.op_b[i*LANE_W +: LANE_W],
                                MODULI[i*LANE_W +: LANE_W]);
                    ALU_SUB: alu_res[i*LANE_W +: LANE_W] =
                        rns_sub(ex.op_a[i*LANE_W +: LANE_W], ex.op_b[i*LANE_W +: LANE_W],
                                MODULI[i*LANE_W +: LANE_W]);
                    ALU_PASS_B: alu_res[i*LANE_W +: LANE_W] = ex.op_b[i*LANE_W +: LANE_W];
                    default: ;
                endcase
            end
            if (ex.alu_op == ALU_CMP) begin
                alu_bc[BC_EQ]  = (ex.op_a == ex.op_b);
                alu_bc[BC_CMP] = 1'b1;
            end
        end
    end

    // Next state and next registered outputs; bubble unless something completes.
    always_comb begin
        state_d     = state_q;
        pend_d      = pend_q;
        res_d       = '0;
        exr_d       = '0;
        bc_d        = '0;
        mul_start_c = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (ex.in_valid) begin
                    if (is_rns && ex.alu_op == ALU_MUL) begin
                        mul_start_c = 1'b1;
                        pend_d      = ex.ID_reg;
                        state_d     = ST_REDUCE;
                    end else begin
                        res_d = alu_res;
                        exr_d = ex.ID_reg;
                        bc_d  = alu_bc;
                    end
                end
            end
            ST_REDUCE: begin
                if (&red_done) begin
                    res_d   = red_res;
                    exr_d   = pend_q;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (ex.flush) begin
            state_d     = ST_IDLE;
            res_d       = '0;
            exr_d       = '0;
            bc_d        = '0;
            mul_start_c = 1'b0;
        end
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q             <= ST_IDLE;
            pend_q              <= '0;
            ex.operation_result <= '0;
            ex.EX_reg           <= '0;
            ex.branch_conds_EX  <= '0;
        end else begin
            state_q             <= state_d;
            pend_q              <= pend_d;
            ex.operation_result <= res_d;
            ex.EX_reg           <= exr_d;
            ex.branch_conds_EX  <= bc_d;
        end
    end
endmodule

// File: tb/tb_pl_ex_stage.sv
// Directed plus random checks of pl_ex_stage with three RNS lanes (moduli 13,11,7).
module tb_pl_ex_stage;
    import pl_pkg::*;

    localparam int unsigned ND = 3;
    localparam int unsigned W  = ND * LANE_W;

    logic clk = 1'b0;
    logic reset;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    pl_ex_stage_if #(.NUM_DOMAINS(ND)) bus ();

    pl_ex_stage #(
        .NUM_DOMAINS  (ND),
        .PROG_CTR_WID (10),
        .MODULI       ({8'd13, 8'd11, 8'd7})
    ) dut (
        .clk   (clk),
        .reset (reset),
        .ex    (bus)
    );

    function automatic int modulus(input int lane);
        case (lane)
            0:       return 7;
            1:       return 11;
            default: return 13;
        endcase
    endfunction

    // Reference ALU straight from the arithmetic rules.
    function automatic void model(input alu_op_e op, input logic rns,
                                  input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] r, output logic [0:4] bc);
        int x, y, m, v;
        r  = '0;
        bc = '0;
        if (!rns) begin
            x = int'(a[7:0]);
            y = int'(b[7:0]);
            v = 0;
            case (op)
                ALU_ADD:    begin v = (x + y) % 256; bc[BC_CARRY] = (x + y) > 255; end
                ALU_SUB:    begin v = (x - y + 256) % 256; bc[BC_CARRY] = (x < y); end
                ALU_AND:    v = x & y;
                ALU_OR:     v = x | y;
                ALU_XOR:    v = x ^ y;
                ALU_PASS_B: v = y;
                ALU_MUL:    begin v = (x * y) % 256; bc[BC_CARRY] = (x * y) / 256 != 0; end
                ALU_CMP:    begin
                    bc[BC_EQ] = (x == y); bc[BC_GT] = (x > y); bc[BC_LT] = (x < y);
                    bc[BC_CMP] = 1'b1;
                end
                default: ;
            endcase
            r[7:0] = 8'(v);
        end else begin
            for (int i = 0; i < ND; i++) begin
                x = int'(a[i*8 +: 8]);
                y = int'(b[i*8 +: 8]);
                m = modulus(i);
                v = 0;
                case (op)
                    ALU_ADD:    v = (x + y) % m;
                    ALU_SUB:    v = (x - y + m) % m;
                    ALU_MUL:    v = (x * y) % m;
                    ALU_PASS_B: v = y;
                    default:    v = 0;
                endcase
                r[i*8 +: 8] = 8'(v);
            end
            if (op == ALU_CMP) begin
                bc[BC_EQ]  = (a == b);
                bc[BC_CMP] = 1'b1;
            end
        end
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input alu_op_e op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [0:7] id);
        bus.in_valid = 1'b1;
        bus.alu_op   = op;
        bus.op_a     = a;
        bus.op_b     = b;
        bus.ID_reg   = id;
    endtask

    task automatic idle();
        bus.in_valid = 1'b0;
        bus.alu_op   = ALU_ADD;
        bus.op_a     = '0;
        bus.op_b     = '0;
        bus.ID_reg   = '0;
    endtask

    task automatic check_out(input string tag, input logic [W-1:0] r, input logic [0:7] id,
                             input logic [0:4] bc);
        check({tag, ".result"}, 32'(bus.operation_result), 32'(r));
        check({tag, ".ex_reg"}, 32'(bus.EX_reg), 32'(id));
        check({tag, ".bc"},     32'(bus.branch_conds_EX), 32'(bc));
    endtask

    task automatic check_bubble(input string tag);
        check_out(tag, '0, '0, '0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [0:7]   id, id2;
        logic [0:4]   bc;
        logic [W-1:0] r, a, b;
        alu_op_e      op;
        logic         rns;

        reset     = 1'b0;
        bus.flush = 1'b0;
        idle();
        step();
        step();
        check_bubble("reset");
        check("reset.stall", 32'(bus.stall_out), 32'd0);
        reset = 1'b1;

        // Binary ADD with carry out
        id = '0; id[EX_SAVE_COUT] = 1'b1; id[EX_REG_WR_EN] = 1'b1;
        drive(ALU_ADD, 24'd200, 24'd100, id);
        step();
        bc = '0; bc[BC_CARRY] = 1'b1;
        check_out("bin_add", 24'h00002C, id, bc);

        // RNS ADD, lanes (2,1,0)
        id = '0; id[EX_DEST_RNS] = 1'b1;
        drive(ALU_ADD, {8'd12, 8'd10, 8'd6}, {8'd4, 8'd5, 8'd3}, id);
        step();
        check_out("rns_add", {8'd3, 8'd4, 8'd2}, id, '0);

        // Binary CMP 5 vs 9
        id = '0;
        drive(ALU_CMP, 24'd5, 24'd9, id);
        step();
        bc = '0; bc[BC_LT] = 1'b1; bc[BC_CMP] = 1'b1;
        check_out("bin_cmp", '0, id, bc);

        // RNS CMP, equal operands
        id = '0; id[EX_DEST_RNS] = 1'b1;
        drive(ALU_CMP, {8'd9, 8'd3, 8'd1}, {8'd9, 8'd3, 8'd1}, id);
        step();
        bc = '0; bc[BC_EQ] = 1'b1; bc[BC_CMP] = 1'b1;
        check_out("rns_cmp_eq", '0, id, bc);

        // RNS MUL with a held follow-on instruction
        id = '0; id[EX_DEST_RNS] = 1'b1; id[EX_REG_WR_EN] = 1'b1;
        drive(ALU_MUL, {8'd12, 8'd10, 8'd6}, {8'd11, 8'd9, 8'd5}, id);
        step();                                   // edge T
        id2 = '0; id2[EX_STORE_TO_MEM] = 1'b1;
        drive(ALU_XOR, 24'h0000F0, 24'h00003C, id2);
        for (int k = 1; k <= 8; k++) begin
            step();
            check("mul.stall", 32'(bus.stall_out), 32'd1);
            check_bubble("mul.wait");
        end
        step();                                   // edge T+9
        check_out("mul.result", {8'd2, 8'd2, 8'd2}, id, '0);
        check("mul.stall_done", 32'(bus.stall_out), 32'd0);
        step();                                   // edge T+10
        check_out("mul.next", 24'h0000CC, id2, '0);
        idle();
        step();
        check_bubble("mul.idle");

        // Flush in the middle of a reduction
        id = '0; id[EX_DEST_RNS] = 1'b1;
        drive(ALU_MUL, {8'd12, 8'd10, 8'd6}, {8'd11, 8'd9, 8'd5}, id);
        step();                                   // T
        idle();
        step(); step(); step();                   // T+1..T+3
        bus.flush = 1'b1;
        id2 = '0; id2[EX_LOAD_TRUE] = 1'b1;
        drive(ALU_ADD, 24'd1, 24'd2, id2);        // must be killed by the flush
        step();                                   // T+4
        check_bubble("flush");
        check("flush.stall", 32'(bus.stall_out), 32'd0);
        bus.flush = 1'b0;
        drive(ALU_ADD, 24'd7, 24'd8, id2);
        step();                                   // T+5
        check_out("flush.add", 24'd15, id2, '0);
        idle();
        for (int k = 0; k < 8; k++) begin
            step();
            check_bubble("flush.no_result");
            check("flush.no_stall", 32'(bus.stall_out), 32'd0);
        end

        // Reset in the middle of a reduction
        id = '0; id[EX_DEST_RNS] = 1'b1;
        drive(ALU_MUL, {8'd12, 8'd10, 8'd6}, {8'd11, 8'd9, 8'd5}, id);
        step();                                   // T
        idle();
        step(); step();                           // T+1, T+2
        reset = 1'b0;
        step();                                   // T+3
        check_bubble("rst_mid");
        check("rst_mid.stall", 32'(bus.stall_out), 32'd0);
        reset = 1'b1;
        step();
        id = '0;
        drive(ALU_SUB, 24'd3, 24'd5, id);
        step();
        bc = '0; bc[BC_CARRY] = 1'b1;
        check_out("bin_sub_borrow", 24'd254, id, bc);
        for (int k = 0; k < 8; k++) begin
            idle();
            step();
            check("rst_mid.no_result", 32'(bus.operation_result), 32'd0);
        end

        // Random operations against the reference model
        for (int n = 0; n < 60; n++) begin
            op  = alu_op_e'(3'($urandom_range(0, 7)));
            rns = 1'($urandom_range(0, 1));
            id  = 8'($urandom);
            id[EX_DEST_RNS] = rns;
            if (rns) begin
                for (int i = 0; i < ND; i++) begin
                    a[i*8 +: 8] = 8'($urandom_range(0, modulus(i) - 1));
                    b[i*8 +: 8] = 8'($urandom_range(0, modulus(i) - 1));
                end
                if (op == ALU_CMP && $urandom_range(0, 1) == 1) b = a;
            end else begin
                a = W'($urandom);
                b = W'($urandom);
            end
            model(op, rns, a, b, r, bc);
            drive(op, a, b, id);
            step();
            if (rns && op == ALU_MUL) begin
                idle();
                for (int k = 1; k <= 8; k++) begin
                    step();
                    check("rand.mul_stall", 32'(bus.stall_out), 32'd1);
                end
                step();
            end
            check_out("rand", r, id, bc);
            check("rand.stall", 32'(bus.stall_out), 32'd0);
        end
        idle();
        step();
        check_bubble("final_bubble");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/pl_ex_stage.md
Name: pl_ex_stage

Overview:
Execute pipeline stage sitting between the ID/EX register and the MEM/WB stage. Runs the ALU operation on binary (lane 0) or RNS (all lanes, per-domain modulus) operands. Registers operation_result, EX_reg and branch_conds_EX for MEM/WB. RNS multiply uses an iterative per-lane modular reducer, stalling the upstream stage while busy.

Parameters:
NUM_DOMAINS, 1, number of 8-bit lanes; lane i = bits [8i+7:8i]; binary ops use lane 0 only
PROG_CTR_WID, 10, carried for interface uniformity; unused internally
MODULI, {NUM_DOMAINS{8'd255}}, packed per-lane moduli, same lane packing; each modulus 2..255

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-low reset
in_valid  in  1  ID stage presents an instruction
alu_op  in  3  0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 MUL, 6 CMP, 7 PASS_B
op_a, op_b  in  NUM_DOMAINS*8  operands
ID_reg  in  [0:7]  control bits, same bit map as EX_reg
flush  in  1  kill the current and in-flight instruction
stall_out  out  1  ID must hold its instruction
operation_result  out  NUM_DOMAINS*8  registered result
EX_reg  out  [0:7]  registered control: store_to_mem, reg_wr_en, save_cout, invalidate_execute_instr, load_true, invalidate_fetch_instr, invalidate_decode_instr, destination_RNS
branch_conds_EX  out  [0:4]  [0] eq, [1] a>b, [2] a<b, [3] carry, [4] compare_true

Behaviour:
- Reset (reset==0 at posedge): all outputs 0, FSM to IDLE, reducer cleared. Takes priority over everything, including mid-multiply.
- Bubble = operation_result 0, EX_reg 0, branch_conds_EX 0. Registered whenever no instruction completes.
- FSM states: IDLE, REDUCE.
- IDLE, in_valid=1, not RNS MUL: result registered at next edge (1-cycle latency). EX_reg <= ID_reg.
- Mode is selected by ID_reg[7]; 0 = binary, 1 = RNS.
- Binary mode:
  - Lane 0 only; upper lanes 0.
  - ADD/SUB are 8-bit; carry = bit 8 of the sum, or borrow for SUB.
  - AND/OR/XOR/PASS_B are bitwise / pass op_b; carry 0.
  - MUL: low byte of the product; carry = OR of the high byte; single cycle.
  - CMP: unsigned a vs b sets [0..2]; [4]=1; result 0.
  - All non-CMP ops: [0..2]=0, [4]=0.
- RNS mode, per lane with m = MODULI lane:
  - ADD: s=a+b (9 b); s>=m ? s-m : s.
  - SUB: a>=b ? a-b : a-b+m.
  - Operands are required < m; out-of-range inputs are not corrected.
  - AND/OR/XOR: result 0.
  - PASS_B: passes op_b.
  - CMP: [0]=all lanes equal; [1],[2]=0; [4]=1.
  - carry is always 0.
- RNS MUL, accepted at edge T:
  - Each lane latches the 16-bit product; FSM goes to REDUCE with cnt=7.
  - Edges T+1..T+8: if p >= (m<<cnt) then p -= m<<cnt; cnt decrements.
  - At edge T+8 the lane holds p mod m. At edge T+9 the result is registered, EX_reg holds the latched ID_reg, and FSM returns to IDLE.
  - Bubbles are output at edges T+1..T+8.
- stall_out = (state==REDUCE); high during cycles T+1..T+8. in_valid is ignored while in REDUCE.
- flush=1 at an edge:
  - Bubble registered; FSM to IDLE; stall_out low next cycle.
  - Overrides a simultaneous in_valid and any reduction in progress.
- Invalidate bits in ID_reg pass through unchanged; masking is done downstream.

Decomposition:
- Package pl_pkg: ALU op codes, EX_reg bit indices, branch_conds indices, LANE_W=8, FSM state enum.
- Sub-module rns_mod_reducer: one lane, iterative shift-subtract, inputs start/flush, output done. Instantiated NUM_DOMAINS times via generate.

Test Plan:
1. NUM_DOMAINS=3, MODULI={13,11,7}, binary ADD 200+100, save_cout set -> next edge: lane0=44, branch_conds_EX[3]=1, EX_reg==ID_reg.
2. RNS ADD a=(12,10,6), b=(4,5,3) [lane2,1,0] -> next edge: result (3,4,2), carry 0.
3. RNS MUL a=(12,10,6), b=(11,9,5) at T -> stall_out high for 8 cycles, bubbles at T+1..T+8, result (2,2,2) at T+9. A held next instruction is accepted at T+10.
4. Binary CMP 5 vs 9 -> branch_conds_EX=[0]0,[1]0,[2]1,[3]0,[4]1; result 0. RNS CMP with equal operands -> [0]=1, [4]=1.
5. flush at T+4 during RNS MUL -> bubble, stall_out low from T+5, no result emitted. New ADD accepted at T+5 completes at T+6.
6. reset low at T+3 during MUL -> all outputs 0, stall_out 0, IDLE. Release reset, then binary SUB 3-5 -> lane0=254, carry=1.
